// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store initiator; byte stores are read-modify-write.
// Optional feature macro: MISALIGN_TRAP_EN (faults misaligned word accesses).
module load_store_unit #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              reqWrite,
    input  logic              reqWord,
    input  logic              reqSigned,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [DATA_W-1:0] reqData,
    output logic              respValid,
    output logic [DATA_W-1:0] respData,
    output logic              respErr,
    output logic              memRead,
    output logic              memWrite,
    output logic              wr_enableBW,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writeWord,
    output logic [7:0]        writeByte,
    input  logic [DATA_W-1:0] readData
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] LAT_RELOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, DONE} state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              phase_end;
    logic              accept;
    logic              trap;
    logic              op_write, op_word, op_signed;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_data;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] resp_data;

    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] rd,
                                                      input logic is_word,
                                                      input logic is_signed,
                                                      input logic hi);
        logic signed [7:0] lane;
        lane = hi ? rd[15:8] : rd[7:0];
        if (is_word)
            return rd;
        if (is_signed)
            return DATA_W'(lane);
        return DATA_W'($unsigned(lane));
    endfunction

    function automatic logic [DATA_W-1:0] rmw_merge(input logic [DATA_W-1:0] rd,
                                                    input logic [DATA_W-1:0] data,
                                                    input logic hi);
        return hi ? {data[7:0], rd[7:0]} : {rd[15:8], data[7:0]};
    endfunction

    assign phase_end = (cnt == '0);
    assign accept    = (state == IDLE) && reqValid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (reqValid) begin
                    cnt_d = LAT_RELOAD;
                    if (trap)
                        state_d = DONE;
                    else if (!reqWrite)
                        state_d = RD;
                    else if (reqWord)
                        state_d = WR;
                    else
                        state_d = RMW_RD;
                end
            end
            RD, WR, RMW_WR: begin
                if (phase_end)
                    state_d = DONE;
                else
                    cnt_d = cnt - 1'b1;
            end
            RMW_RD: begin
                if (phase_end) begin
                    state_d = RMW_WR;
                    cnt_d   = LAT_RELOAD;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // request latch, read capture and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            op_write  <= 1'b0;
            op_word   <= 1'b0;
            op_signed <= 1'b0;
            op_addr   <= '0;
            op_data   <= '0;
            rd_word   <= '0;
            resp_data <= '0;
        end else begin
            if (accept) begin
                op_write  <= reqWrite;
                op_word   <= reqWord;
                op_signed <= reqSigned;
                op_addr   <= reqAddr;
                op_data   <= reqData;
            end
            if (state == RD && phase_end)
                resp_data <= load_extend(readData, op_word, op_signed, op_addr[0]);
            if (state == RMW_RD && phase_end)
                rd_word <= readData;
            if ((state == WR || state == RMW_WR) && phase_end)
                resp_data <= '0;
            if (accept && trap)
                resp_data <= '0;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic resp_err;
    assign trap = reqWord && reqAddr[0];
    // error flag is refreshed on every entry into DONE; only a trap enters from IDLE
    always_ff @(posedge clk) begin
        if (rst)
            resp_err <= 1'b0;
        else if (state_d == DONE && state != DONE)
            resp_err <= (state == IDLE);
    end
    assign respErr = resp_err;
`else
    assign trap    = 1'b0;
    assign respErr = 1'b0;
`endif

    always_comb begin
        reqReady    = (state == IDLE);
        respValid   = (state == DONE);
        memRead     = (state == RD) || (state == RMW_RD);
        memWrite    = (state == WR) || (state == RMW_WR);
        wr_enableBW = memWrite;
        address     = {1'b0, op_addr[ADDR_W-1:1]};
        writeWord   = '0;
        if (state == WR)
            writeWord = op_data;
        else if (state == RMW_WR)
            writeWord = rmw_merge(rd_word, op_data, op_addr[0]);
    end

    assign respData  = resp_data;
    assign writeByte = writeWord[7:0];

    // op_write is kept for debug visibility of the latched request
    logic unused_ok;
    assign unused_ok = op_write;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (MEM_LAT=1 and MEM_LAT=3), a timing/memory model,
// a per-cycle compare process and directed transactions with literal expectations.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst;
    logic mem_init;
    logic chk_en;
    int   total = 0;
    int   bad   = 0;

    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic        req_word  [2];
    logic        req_signed[2];
    logic [15:0] req_addr  [2];
    logic [15:0] req_data  [2];
    logic        resp_valid[2];
    logic [15:0] resp_data [2];
    logic        resp_err  [2];
    logic        mem_read  [2];
    logic        mem_write [2];
    logic        wr_en_bw  [2];
    logic [15:0] address   [2];
    logic [15:0] write_word[2];
    logic [7:0]  write_byte[2];
    logic [15:0] read_data [2];

    logic [15:0] mem_phys[2][16];

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u0 (
        .clk(clk), .rst(rst), .reqValid(req_valid[0]), .reqReady(req_ready[0]),
        .reqWrite(req_write[0]), .reqWord(req_word[0]), .reqSigned(req_signed[0]),
        .reqAddr(req_addr[0]), .reqData(req_data[0]), .respValid(resp_valid[0]),
        .respData(resp_data[0]), .respErr(resp_err[0]), .memRead(mem_read[0]),
        .memWrite(mem_write[0]), .wr_enableBW(wr_en_bw[0]), .address(address[0]),
        .writeWord(write_word[0]), .writeByte(write_byte[0]), .readData(read_data[0]));

    load_store_unit #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) u1 (
        .clk(clk), .rst(rst), .reqValid(req_valid[1]), .reqReady(req_ready[1]),
        .reqWrite(req_write[1]), .reqWord(req_word[1]), .reqSigned(req_signed[1]),
        .reqAddr(req_addr[1]), .reqData(req_data[1]), .respValid(resp_valid[1]),
        .respData(resp_data[1]), .respErr(resp_err[1]), .memRead(mem_read[1]),
        .memWrite(mem_write[1]), .wr_enableBW(wr_en_bw[1]), .address(address[1]),
        .writeWord(write_word[1]), .writeByte(write_byte[1]), .readData(read_data[1]));

    function automatic logic [15:0] preload(input int j);
        case (j)
            2:       return 16'h4312;
            3:       return 16'hBEDE;
            4:       return 16'hADEF;
            default: return 16'h0000;
        endcase
    endfunction

    // data memory behind each instance
    always_comb begin
        for (int i = 0; i < 2; i++)
            read_data[i] = mem_phys[i][address[i][3:0]];
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_init) begin
                for (int j = 0; j < 16; j++)
                    mem_phys[i][j] <= preload(j);
            end else if (mem_write[i]) begin
                mem_phys[i][address[i][3:0]] <= write_word[i];
            end
        end
    end

    // reference model: cycle count since accept plus expected memory contents
    logic        m_busy[2];
    int          m_k   [2];
    logic        m_wr  [2];
    logic        m_wd  [2];
    logic        m_sg  [2];
    logic        m_trap[2];
    logic [15:0] m_addr[2];
    logic [15:0] m_data[2];
    logic [15:0] m_last[2];
    logic [15:0] ref_mem[2][16];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int total_of(input int i);
        if (m_trap[i])
            return 1;
        if (!m_wr[i] || m_wd[i])
            return lat_of(i) + 1;
        return 2 * lat_of(i) + 1;
    endfunction

    function automatic logic [15:0] merged(input int i);
        logic [15:0] w;
        w = ref_mem[i][m_addr[i][4:1]];
        return m_addr[i][0] ? {m_data[i][7:0], w[7:0]} : {w[15:8], m_data[i][7:0]};
    endfunction

    function automatic logic [15:0] fresh(input int i);
        logic [15:0] w;
        logic [7:0]  b;
        w = ref_mem[i][m_addr[i][4:1]];
        b = m_addr[i][0] ? w[15:8] : w[7:0];
        if (m_trap[i] || m_wr[i])
            return 16'h0000;
        if (m_wd[i])
            return w;
        return {(m_sg[i] ? {8{b[7]}} : 8'h00), b};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_init) begin
                for (int j = 0; j < 16; j++)
                    ref_mem[i][j] <= preload(j);
            end
            if (rst) begin
                m_busy[i] <= 1'b0;
                m_k[i]    <= 0;
                m_last[i] <= 16'h0000;
                m_trap[i] <= 1'b0;
                m_wr[i]   <= 1'b0;
                m_wd[i]   <= 1'b0;
            end else if (!m_busy[i]) begin
                if (req_valid[i]) begin
                    m_busy[i] <= 1'b1;
                    m_k[i]    <= 1;
                    m_wr[i]   <= req_write[i];
                    m_wd[i]   <= req_word[i];
                    m_sg[i]   <= req_signed[i];
                    m_addr[i] <= req_addr[i];
                    m_data[i] <= req_data[i];
`ifdef MISALIGN_TRAP_EN
                    m_trap[i] <= req_word[i] && req_addr[i][0];
`else
                    m_trap[i] <= 1'b0;
`endif
                end
            end else begin
                if (m_k[i] == total_of(i)) begin
                    m_busy[i] <= 1'b0;
                    m_last[i] <= fresh(i);
                    if (m_wr[i] && !m_trap[i])
                        ref_mem[i][m_addr[i][4:1]] <= m_wd[i] ? m_data[i] : merged(i);
                end
                m_k[i] <= m_k[i] + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // per-cycle comparison against the model
    always @(negedge clk) begin
        int          ck, cl;
        logic        cb, e_rd, e_wr, e_rv;
        logic [15:0] e_data, e_ww;
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                cb     = m_busy[i];
                ck     = m_k[i];
                cl     = lat_of(i);
                e_rd   = cb && !m_trap[i] && !(m_wr[i] && m_wd[i]) && (ck <= cl);
                e_wr   = cb && !m_trap[i] && m_wr[i] &&
                         (m_wd[i] ? (ck <= cl) : (ck > cl && ck <= 2 * cl));
                e_rv   = cb && (ck == total_of(i));
                e_data = e_rv ? fresh(i) : m_last[i];
                e_ww   = m_wd[i] ? m_data[i] : merged(i);
                chk($sformatf("u%0d.reqReady", i), 32'(req_ready[i]), 32'(!cb));
                chk($sformatf("u%0d.memRead", i), 32'(mem_read[i]), 32'(e_rd));
                chk($sformatf("u%0d.memWrite", i), 32'(mem_write[i]), 32'(e_wr));
                chk($sformatf("u%0d.wr_enableBW", i), 32'(wr_en_bw[i]), 32'(e_wr));
                chk($sformatf("u%0d.respValid", i), 32'(resp_valid[i]), 32'(e_rv));
                chk($sformatf("u%0d.respData", i), 32'(resp_data[i]), 32'(e_data));
                if (e_rv)
                    chk($sformatf("u%0d.respErr", i), 32'(resp_err[i]), 32'(m_trap[i]));
                if (e_rd || e_wr)
                    chk($sformatf("u%0d.address", i), 32'(address[i]), 32'(m_addr[i] >> 1));
                if (e_wr) begin
                    chk($sformatf("u%0d.writeWord", i), 32'(write_word[i]), 32'(e_ww));
                    chk($sformatf("u%0d.writeByte", i), 32'(write_byte[i]), 32'(e_ww[7:0]));
                end
            end
        end
    end

    task automatic run_op(input int i, input logic wr, input logic wd, input logic sg,
                          input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] rdata, output int lat, output int nrd,
                          output int nwr, output int nbusy, output logic [15:0] ad,
                          output logic [15:0] ww);
        logic done;
        @(negedge clk);
        req_write[i]  = wr;
        req_word[i]   = wd;
        req_signed[i] = sg;
        req_addr[i]   = a;
        req_data[i]   = d;
        req_valid[i]  = 1'b1;
        @(negedge clk);
        req_valid[i] = 1'b0;
        lat = 1; nrd = 0; nwr = 0; nbusy = 0; ad = 16'hxxxx; ww = 16'hxxxx;
        done = 1'b0;
        while (!done) begin
            if (mem_read[i]) begin nrd++; ad = address[i]; end
            if (mem_write[i]) begin nwr++; ad = address[i]; ww = write_word[i]; end
            if (!req_ready[i]) nbusy++;
            if (resp_valid[i] || lat >= 40) begin
                done = 1'b1;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        if (!resp_valid[i]) begin
            total++;
            bad++;
            $display("FAIL u%0d.timeout: no respValid within %0d cycles", i, lat);
        end
        rdata = resp_data[i];
    endtask

    initial begin
        logic [15:0] r, ad, ww;
        int          lt, nr, nw, nb, cnt_rv, cnt_wr;
        rst = 1'b1; mem_init = 1'b1; chk_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_write[i] = 1'b0; req_word[i] = 1'b0;
            req_signed[i] = 1'b0; req_addr[i] = 16'h0; req_data[i] = 16'h0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; mem_init = 1'b0; chk_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("rst.reqReady", 32'(req_ready[i]), 32'd1);
            chk("rst.respValid", 32'(resp_valid[i]), 32'd0);
            chk("rst.memRead", 32'(mem_read[i]), 32'd0);
            chk("rst.memWrite", 32'(mem_write[i]), 32'd0);
            chk("rst.wr_enableBW", 32'(wr_en_bw[i]), 32'd0);
            chk("rst.address", 32'(address[i]), 32'd0);
            chk("rst.writeWord", 32'(write_word[i]), 32'd0);
            chk("rst.respData", 32'(resp_data[i]), 32'd0);
            chk("rst.respErr", 32'(resp_err[i]), 32'd0);
        end

        // MEM_LAT=1 instance
        run_op(0, 0, 1, 0, 16'h0006, 16'h0, r, lt, nr, nw, nb, ad, ww);
        chk("lw6.data", 32'(r), 32'hBEDE);
        chk("lw6.lat", 32'(lt), 32'd2);
        chk("lw6.nrd", 32'(nr), 32'd1);
        chk("lw6.addr", 32'(ad), 32'd3);
        run_op(0, 0, 0, 1, 16'h0007, 16'h0, r, lt, nr, nw, nb, ad, ww);
        chk("lb7.data", 32'(r), 32'hFFBE);
        run_op(0, 0, 0, 0, 16'h0007, 16'h0, r, lt, nr, nw, nb, ad, ww);
        chk("lbu7.data", 32'(r), 32'h00BE);
        run_op(0, 0, 0, 0, 16'h0004, 16'h0, r, lt, nr, nw, nb, ad, ww);
        chk("lbu4.data", 32'(r), 32'h0012);
        run_op(0, 1, 0, 0, 16'h0008, 16'h0077, r, lt, nr, nw, nb, ad, ww);
        chk("sb8.lat", 32'(lt), 32'd3);
        chk("sb8.ww", 32'(ww), 32'hAD77);
        chk("sb8.addr", 32'(ad), 32'd4);
        chk("sb8.nrd", 32'(nr), 32'd1);
        chk("sb8.nwr", 32'(nw), 32'd1);
        chk("sb8.resp", 32'(r), 32'h0000);
        chk("sb8.mem4", 32'(mem_phys[0][4]), 32'hAD77);
        run_op(0, 0, 1, 0, 16'h0008, 16'h0, r, lt, nr, nw, nb, ad, ww);
        chk("lw8.data", 32'(r), 32'hAD77);
        run_op(0, 1, 0, 0, 16'h0009, 16'h5555, r, lt, nr, nw, nb, ad, ww);
        chk("sb9.ww", 32'(ww), 32'h5577);
        run_op(0, 0, 0, 1, 16'h0008, 16'h0, r, lt, nr, nw, nb, ad, ww);
        chk("lb8.data", 32'(r), 32'h0077);
`ifdef MISALIGN_TRAP_EN
        run_op(0, 0, 1, 0, 16'h0003, 16'h0, r, lt, nr, nw, nb, ad, ww);
        chk("trap.lat", 32'(lt), 32'd1);
        chk("trap.nrd", 32'(nr), 32'd0);
        chk("trap.err", 32'(resp_err[0]), 32'd1);
        chk("trap.data", 32'(r), 32'h0000);
`else
        run_op(0, 0, 1, 0, 16'h0007, 16'h0, r, lt, nr, nw, nb, ad, ww);
        chk("lw7.data", 32'(r), 32'hBEDE);
        chk("lw7.err", 32'(resp_err[0]), 32'd0);
`endif

        // MEM_LAT=3 instance
        run_op(1, 1, 1, 0, 16'h0004, 16'h1234, r, lt, nr, nw, nb, ad, ww);
        chk("sw4.nwr", 32'(nw), 32'd3);
        chk("sw4.busy", 32'(nb), 32'd4);
        chk("sw4.lat", 32'(lt), 32'd4);
        chk("sw4.mem2", 32'(mem_phys[1][2]), 32'h1234);
        run_op(1, 0, 1, 0, 16'h0004, 16'h0, r, lt, nr, nw, nb, ad, ww);
        chk("lw4.data", 32'(r), 32'h1234);
        chk("lw4.nrd", 32'(nr), 32'd3);
        run_op(1, 1, 0, 0, 16'h0005, 16'h00AB, r, lt, nr, nw, nb, ad, ww);
        chk("sb5.lat", 32'(lt), 32'd7);
        chk("sb5.ww", 32'(ww), 32'hAB34);

        // reset during RMW_RD of a byte store
        @(negedge clk);
        req_write[1] = 1'b1; req_word[1] = 1'b0; req_signed[1] = 1'b0;
        req_addr[1] = 16'h0006; req_data[1] = 16'h0011; req_valid[1] = 1'b1;
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("rmw.memRead", 32'(mem_read[1]), 32'd1);
        rst = 1'b1;
        cnt_rv = 0; cnt_wr = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            if (resp_valid[1]) cnt_rv++;
            if (mem_write[1]) cnt_wr++;
            @(negedge clk);
        end
        chk("rmwrst.respValid", 32'(cnt_rv), 32'd0);
        chk("rmwrst.memWrite", 32'(cnt_wr), 32'd0);
        chk("rmwrst.mem3", 32'(mem_phys[1][3]), 32'hBEDE);

        // reset and request on the same edge: reset wins
        rst = 1'b1;
        req_write[0] = 1'b0; req_word[0] = 1'b1; req_addr[0] = 16'h0006; req_valid[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0; req_valid[0] = 1'b0;
        cnt_rv = 0; nr = 0;
        repeat (5) begin
            if (resp_valid[0]) cnt_rv++;
            if (mem_read[0]) nr++;
            @(negedge clk);
        end
        chk("rstreq.respValid", 32'(cnt_rv), 32'd0);
        chk("rstreq.memRead", 32'(nr), 32'd0);

        run_op(1, 0, 1, 0, 16'h0006, 16'h0, r, lt, nr, nw, nb, ad, ww);
        chk("recover.data", 32'(r), 32'hBEDE);
        chk("recover.lat", 32'(lt), 32'd4);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
